// File: rtl/data_memory_ctrl.sv
// Handshaked data memory with configurable wait states and a registered response.
// Misaligned, out-of-range and illegal-size accesses come back as resp_err.
module data_memory_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MEM_SIZE      = 64,
  parameter int unsigned LATENCY       = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     resp_err
);

  localparam int unsigned IDX_W    = $clog2(MEM_SIZE);
  localparam logic        ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]  CNT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                   r_state;
  logic [3:0]               r_cnt;
  logic                     r_write;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic                     r_resp_valid;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_resp_err;
  logic [DATA_WIDTH-1:0]    r_mem [MEM_SIZE] = '{default: '0};

  logic                     w_in_idle;
  logic                     w_commit;
  logic                     w_write;
  logic [2:0]               w_f3;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [IDX_W-1:0]         w_idx;
  logic                     w_oor;
  logic                     w_misal;
  logic                     w_bad_f3;
  logic                     w_err;
  logic [DATA_WIDTH-1:0]    w_word;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [DATA_WIDTH-1:0]    w_load;
  logic [3:0]               w_wmask;
  logic [DATA_WIDTH-1:0]    w_wword;

  // With zero latency the commit happens on the accept edge, so use the live request.
  assign w_in_idle = (r_state == S_IDLE);
  assign w_write   = w_in_idle ? req_write : r_write;
  assign w_f3      = w_in_idle ? funct3    : r_funct3;
  assign w_addr    = w_in_idle ? addr      : r_addr;
  assign w_wdata   = w_in_idle ? wdata     : r_wdata;
  assign w_commit  = !rst && ((w_in_idle && req_valid && ZERO_LAT) ||
                              (r_state == S_WAIT && r_cnt == 4'd0));

  assign w_idx    = w_addr[IDX_W+1:2];
  assign w_oor    = (w_addr >> (IDX_W + 2)) != '0;
  assign w_misal  = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                    ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_bad_f3 = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111) ||
                    (w_write && w_f3[2]);
  assign w_err    = w_oor || w_misal || w_bad_f3;

  assign w_word = r_mem[w_idx];
  assign w_byte = 8'(w_word >> {w_addr[1:0], 3'b000});
  assign w_half = 16'(w_word >> {w_addr[1], 4'b0000});

  always_comb begin
    w_load = '0;
    case (w_f3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = '0;
    endcase
  end

  // Replicate store data across lanes; the mask picks the lanes actually written.
  always_comb begin
    w_wmask = 4'b1111;
    w_wword = w_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_wmask = 4'b0001 << w_addr[1:0];
        w_wword = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_wmask = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wword = {2{w_wdata[15:0]}};
      end
      default: begin
        w_wmask = 4'b1111;
        w_wword = w_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wmask[i]) r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_funct3 <= funct3;
            r_addr   <= addr;
            r_wdata  <= wdata;
            if (ZERO_LAT) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_err;
        r_rdata      <= (w_err || w_write) ? '0 : w_load;
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign rdata      = r_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a zero-latency instance driven from a
// vector table and a three-wait-state instance for timing and reset corners.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        rv  [2];
  logic        wr  [2];
  logic [2:0]  f3  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];
  logic        rdy [2];
  logic        vld [2];
  logic [31:0] rd  [2];
  logic        err [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(64), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(wr[0]),
    .funct3(f3[0]), .addr(ad[0]), .wdata(wd[0]), .resp_valid(vld[0]), .rdata(rd[0]),
    .resp_err(err[0]));

  data_memory_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(64), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(wr[1]),
    .funct3(f3[1]), .addr(ad[1]), .wdata(wd[1]), .resp_valid(vld[1]), .rdata(rd[1]),
    .resp_err(err[1]));

  typedef struct {
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Issue one request on instance d and wait (bounded) for its response.
  task automatic do_req(input int d, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] data, input bit scramble,
                        output logic [31:0] r, output logic e, output int lat, output bit rdy_low);
    int guard = 0;
    while (!rdy[d] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    rv[d] = 1'b1; wr[d] = w; f3[d] = f; ad[d] = a; wd[d] = data;
    @(posedge clk); #1;
    rv[d] = 1'b0;
    if (scramble) begin
      wr[d] = ~w; ad[d] = ~a; wd[d] = ~data;
    end
    lat = -1;
    rdy_low = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (rdy[d]) rdy_low = 1'b0;
      if (vld[d]) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    r = rd[d];
    e = err[d];
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    bit          rl;
    bit          seen;

    tbl.push_back('{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFBE, 1'b0});
    tbl.push_back('{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0});
    tbl.push_back('{1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b1, 3'b000, 32'h21,  32'hAB55,     32'h00000000, 1'b0});
    tbl.push_back('{1'b1, 3'b001, 32'h22,  32'hCD1234,   32'h00000000, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h20,  32'h0,        32'h12345500, 1'b0});
    tbl.push_back('{1'b0, 3'b000, 32'h21,  32'h0,        32'h00000055, 1'b0});
    tbl.push_back('{1'b0, 3'b001, 32'h20,  32'h0,        32'h00005500, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h22,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b001, 32'h05,  32'hFFFF,     32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 32'h100, 32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b100, 32'h10,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 3'b110, 32'h10,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b101, 32'h20,  32'h0,        32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b000, 32'h100, 32'hFF,       32'h00000000, 1'b1});
    tbl.push_back('{1'b1, 3'b010, 32'h06,  32'hFFFFFFFF, 32'h00000000, 1'b1});
    tbl.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h20,  32'h0,        32'h12345500, 1'b0});
    tbl.push_back('{1'b0, 3'b010, 32'h04,  32'h0,        32'h00000000, 1'b0});

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; wr[d] = 1'b0; f3[d] = 3'b000; ad[d] = '0; wd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("rst_valid%0d", d), 32'(vld[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rd[d], 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst0", 32'(rdy[0]), 32'd1);
    chk("ready_after_rst3", 32'(rdy[1]), 32'd1);

    // Zero-latency instance: vector table.
    foreach (tbl[i]) begin
      do_req(0, tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].d, 1'b0, r, e, lat, rl);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd0);
      chk($sformatf("v%0d_rdata", i), r, tbl[i].exp_rd);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
      @(posedge clk); #1;
      chk($sformatf("v%0d_strobe_drop", i), 32'(vld[0]), 32'd0);
      chk($sformatf("v%0d_rdata_hold", i), rd[0], tbl[i].exp_rd);
      chk($sformatf("v%0d_ready_back", i), 32'(rdy[0]), 32'd1);
    end

    // LATENCY=3: timing and input changes during the wait states.
    do_req(1, 1'b1, 3'b010, 32'h40, 32'h11223344, 1'b1, r, e, lat, rl);
    chk("l3_sw_lat", 32'(lat), 32'd3);
    chk("l3_sw_ready_low", 32'(rl), 32'd1);
    chk("l3_sw_err", 32'(e), 32'd0);
    @(posedge clk); #1;
    chk("l3_sw_strobe_drop", 32'(vld[1]), 32'd0);
    chk("l3_sw_ready_back", 32'(rdy[1]), 32'd1);
    do_req(1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, r, e, lat, rl);
    chk("l3_lw_lat", 32'(lat), 32'd3);
    chk("l3_lw_ready_low", 32'(rl), 32'd1);
    chk("l3_lw_rdata", r, 32'h11223344);
    chk("l3_lw_err", 32'(e), 32'd0);
    @(posedge clk); #1;

    // Reset while in WAIT abandons the store.
    rv[1] = 1'b1; wr[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h30; wd[1] = 32'hAAAAAAAA;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_wait_valid", 32'(vld[1]), 32'd0);
    chk("rst_wait_rdata", rd[1], 32'd0);
    chk("rst_wait_ready", 32'(rdy[1]), 32'd0);
    rst[1] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (vld[1]) seen = 1'b1;
    end
    chk("rst_wait_no_resp", 32'(seen), 32'd0);
    chk("rst_wait_ready_back", 32'(rdy[1]), 32'd1);
    do_req(1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, r, e, lat, rl);
    chk("rst_wait_lw_rdata", r, 32'h00000000);
    chk("rst_wait_lw_err", 32'(e), 32'd0);
    @(posedge clk); #1;

    // Reset sampled on the commit edge also suppresses the write.
    rv[1] = 1'b1; wr[1] = 1'b1; f3[1] = 3'b010; ad[1] = 32'h34; wd[1] = 32'hBBBBBBBB;
    @(posedge clk); #1;
    rv[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_commit_valid", 32'(vld[1]), 32'd0);
    chk("rst_commit_err", 32'(err[1]), 32'd0);
    rst[1] = 1'b0;
    @(posedge clk); #1;
    do_req(1, 1'b0, 3'b010, 32'h34, 32'h0, 1'b0, r, e, lat, rl);
    chk("rst_commit_lw_rdata", r, 32'h00000000);
    chk("rst_commit_lw_lat", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Handshaked, parametrised data memory for the multi-cycle and memory-latency pipeline variants; successor to the single-cycle data memory in the memory stage. Accepts one load/store request at a time over a valid/ready interface and waits a configurable number of cycles before returning a registered response. Flags misaligned, out-of-range and illegal-size accesses instead of silently wrapping the address.

## Interface
- ADDRESS_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, word width; only 32 is supported
- MEM_SIZE, 64, depth in words; power of two, at least 2
- LATENCY, 0, wait-state cycles inserted before the response; 0..15

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- funct3  in  3  access size/sign, RV32I encoding (000 b, 001 h, 010 w, 100 bu, 101 hu)
- addr  in  ADDRESS_WIDTH  byte address
- wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- rdata  out  DATA_WIDTH  load result, extended; 0 for stores and errors
- resp_err  out  1  access rejected, valid with resp_valid

## Operation
- FSM states: IDLE, WAIT, RESP. req_ready = (state == IDLE) && !rst.
- IDLE: on req_valid && req_ready, latch req_write, funct3, addr and wdata. Go to WAIT if LATENCY > 0, else to RESP. Later changes on the inputs have no effect.
- WAIT: a 4-bit counter loaded with LATENCY-1 counts down. At 0, go to RESP.
- Commit edge is the edge that enters RESP. At that edge, the block checks the request, writes memory and registers rdata/resp_err.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Error conditions (resp_err = 1, memory unchanged, rdata = 0):
  - lh/lhu/sh with addr[0] = 1
  - lw/sw with addr[1:0] != 0
  - addr >= 4*MEM_SIZE
  - funct3 in {011, 110, 111}
  - store with funct3 100 or 101
- Loads:
  - The byte or halfword is selected by addr[1:0].
  - lb/lh sign-extend from the selected field's own MSB.
  - lbu/lhu zero-extend.
  - lw returns the word unchanged.
- Stores:
  - sb writes only the addressed byte lane.
  - sh writes only the addressed half.
  - sw writes the whole word.
  - Other lanes are preserved.
- Memory contents are zeroed at time 0 by initialisation only; rst does not clear memory.

## Timing
- Reset values: state IDLE, resp_valid 0, rdata 0, resp_err 0, counter 0; req_ready 0 while rst is high, 1 in the first cycle after.
- Latency: request accepted at edge N. resp_valid is high in the cycle after edge N+LATENCY, so the request-to-response time is LATENCY+1 cycles.
- Throughput: one request per LATENCY+2 cycles. req_ready is low in WAIT and RESP and returns high in the cycle after resp_valid.
- rdata and resp_err hold their values after resp_valid falls, until the next commit.
- A load immediately following a store to the same word observes the stored data.
- rst mid-operation, in WAIT or at the commit edge:
  - The pending request is abandoned.
  - No write occurs and no response is issued.
  - Outputs return to reset values at that edge.
- req_valid while req_ready = 0 is ignored; the requester must hold the request until it sees req_ready.

## Test plan
- Reset then sw 0xDEADBEEF @0x10, then lw @0x10 with LATENCY=0 -> each resp_valid arrives 1 cycle after acceptance; second rdata = 0xDEADBEEF, resp_err = 0.
- With word @0x10 = 0xDEADBEEF: lb @0x11 -> 0xFFFFFFBE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF.
- sb 0x55 @0x21, then sh 0x1234 @0x22, then lw @0x20 (word initially 0) -> 0x12345500.
- LATENCY=3:
  - Accept at edge N -> resp_valid high only in the cycle after edge N+3; req_ready low during N+1..N+3, high again after.
  - Changing addr/wdata during WAIT does not change the result.
- Errors:
  - lw @0x22 -> resp_err = 1.
  - sh @0x05 -> resp_err = 1.
  - lw @4*MEM_SIZE -> resp_err = 1.
  - Store with funct3 = 100 -> resp_err = 1.
  - funct3 = 011 -> resp_err = 1.
  - Every error case -> rdata = 0 and memory unchanged.
- LATENCY=3, rst asserted during WAIT of sw 0xAAAAAAAA @0x30 -> no resp_valid; a following lw @0x30 -> 0x00000000.
